// File: rtl/coarse_ctrl_sequencer.sv
// Coarse channeliser control sequencer: decodes the software control word,
// arms/gates the sync pulse into the FFT datapath and keeps status counters.
module coarse_ctrl_sequencer #(
    parameter int unsigned HOLDOFF_CYCLES = 16,
    parameter int unsigned SHIFT_W        = 12
) (
    input  logic               OPB_Clk,
    input  logic               OPB_Rst,
    input  logic [31:0]        ctrl_word,
    input  logic               sync_in,
    input  logic               fft_of,
    output logic               sync_out,
    output logic [SHIFT_W-1:0] fft_shift,
    output logic               dp_rst,
    output logic               armed,
    output logic [7:0]         sync_cnt,
    output logic [15:0]        of_cnt,
    output logic [31:0]        status_word
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        FIRE    = 2'd2,
        HOLDOFF = 2'd3
    } state_t;

    localparam logic [15:0] HOLD_LOAD = 16'(HOLDOFF_CYCLES - 1);

    state_t             state, state_nxt;
    logic               pending, pending_nxt;
    logic [15:0]        hold_cnt, hold_nxt;
    logic [SHIFT_W-1:0] shift_stage, stage_nxt;
    logic [SHIFT_W-1:0] shift_nxt;
    logic [1:0]         cmd_q;
    logic               arm_e, clr_e;
    logic [SHIFT_W-1:0] shift_in;
    logic               unused_bits;

    assign arm_e       = ctrl_word[0] & ~cmd_q[0];
    assign clr_e       = ctrl_word[1] & ~cmd_q[1];
    assign shift_in    = ctrl_word[4 +: SHIFT_W];
    assign unused_bits = ^{ctrl_word[30:4+SHIFT_W], ctrl_word[3:2]};

    assign sync_out = (state == FIRE);
    assign armed    = (state == ARMED);

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        hold_nxt    = hold_cnt;
        stage_nxt   = shift_stage;
        shift_nxt   = fft_shift;
        // The level reset of the datapath overrides every sequencing decision.
        if (ctrl_word[31]) begin
            state_nxt   = IDLE;
            pending_nxt = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (arm_e) begin
                        stage_nxt = shift_in;
                        state_nxt = ARMED;
                    end
                end
                ARMED: begin
                    if (arm_e) stage_nxt = shift_in;
                    if (sync_in) begin
                        state_nxt = FIRE;
                        shift_nxt = arm_e ? shift_in : shift_stage;
                    end
                end
                FIRE: begin
                    hold_nxt  = HOLD_LOAD;
                    state_nxt = HOLDOFF;
                end
                HOLDOFF: begin
                    if (arm_e) begin
                        pending_nxt = 1'b1;
                        stage_nxt   = shift_in;
                    end
                    if (hold_cnt == 16'd0) begin
                        state_nxt   = (pending || arm_e) ? ARMED : IDLE;
                        pending_nxt = 1'b0;
                    end else begin
                        hold_nxt = hold_cnt - 16'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            state       <= IDLE;
            pending     <= 1'b0;
            hold_cnt    <= '0;
            shift_stage <= '1;
            fft_shift   <= '1;
            cmd_q       <= '0;
            dp_rst      <= 1'b0;
        end else begin
            state       <= state_nxt;
            pending     <= pending_nxt;
            hold_cnt    <= hold_nxt;
            shift_stage <= stage_nxt;
            fft_shift   <= shift_nxt;
            cmd_q       <= ctrl_word[1:0];
            dp_rst      <= ctrl_word[31];
        end
    end

    // A clear command beats any increment landing on the same edge.
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            sync_cnt    <= '0;
            of_cnt      <= '0;
            status_word <= '0;
        end else begin
            if (clr_e)              sync_cnt <= '0;
            else if (state == FIRE) sync_cnt <= sync_cnt + 8'd1;
            if (clr_e)                            of_cnt <= '0;
            else if (fft_of && of_cnt != 16'hFFFF) of_cnt <= of_cnt + 16'd1;
            status_word <= {of_cnt, sync_cnt, 5'b0, pending, state};
        end
    end

endmodule

// File: doc/coarse_ctrl_sequencer.md
# coarse_ctrl_sequencer

Sequencer between the coarse-channeliser control software register (32-bit control word) and the coarse FFT datapath. Decodes the control word, detects edge-triggered commands, arms and gates the external sync pulse into the datapath, applies staged FFT shift settings on an armed sync, and keeps sync/overflow status counters for readback via a companion status register.

## Interface
- HOLDOFF_CYCLES, 16: cycles after an emitted sync during which re-arming is deferred; range 1..65535.
- SHIFT_W, 12: width of the FFT shift schedule field.
- OPB_Clk  in  1  single clock; all logic is on its rising edge.
- OPB_Rst  in  1  reset, asynchronous, active-high.
- ctrl_word  in  32  control word from the software register, synchronous to OPB_Clk. Fields:
  - [0] arm (rising-edge command)
  - [1] clr_status (rising-edge command)
  - [4+SHIFT_W-1:4] shift value
  - [31] dp_rst (level)
- sync_in  in  1  raw sync pulse from the timing distribution; one cycle wide.
- fft_of  in  1  FFT overflow flag, one per cycle.
- sync_out  out  1  gated sync to the coarse datapath.
- fft_shift  out  SHIFT_W  active FFT shift schedule.
- dp_rst  out  1  registered datapath reset.
- armed  out  1  high in ARMED state.
- sync_cnt  out  8  count of emitted sync_out pulses.
- of_cnt  out  16  count of cycles with fft_of high.
- status_word  out  32  {of_cnt, sync_cnt, 5'b0, pending, state[1:0]} (MSB first).

## Operation
- ctrl_word is registered once to ctrl_q. Edge detects are `arm_e = ctrl_word[0] & ~ctrl_q[0]` and `clr_e = ctrl_word[1] & ~ctrl_q[1]`.
- State machine has four states: IDLE=0, ARMED=1, FIRE=2, HOLDOFF=3.
- IDLE:
  - On arm_e, capture shift_stage = ctrl_word shift field and go to ARMED.
  - sync_in is ignored.
- ARMED:
  - On sync_in, go to FIRE.
  - A further arm_e re-captures shift_stage and stays in ARMED.
- FIRE (exactly one cycle):
  - sync_out=1, fft_shift <= shift_stage, sync_cnt increments.
  - Load holdoff counter with HOLDOFF_CYCLES-1, then go to HOLDOFF.
- HOLDOFF:
  - Counter decrements each cycle; sync_in is ignored.
  - arm_e sets pending=1 and captures shift_stage.
  - When the counter reaches 0, go to ARMED if pending, else IDLE; clear pending either way.
- dp_rst = registered ctrl_word[31]. While dp_rst=1:
  - State is forced to IDLE and pending is cleared.
  - Counters and fft_shift are retained.
- sync_cnt is 8-bit and wraps 255 -> 0.
- of_cnt increments on fft_of and saturates at 0xFFFF.
- clr_e zeroes both counters. If clr_e coincides with an increment in the same cycle, clear wins and the result is 0.
- Reset values: state IDLE; sync_out, armed, dp_rst, pending, sync_cnt, of_cnt all 0; fft_shift all ones (full shift); shift_stage all ones; ctrl_q 0.

## Timing
- ctrl_word change at edge n -> edge detect valid in cycle n. armed=1 from cycle n+1.
- sync_in high in cycle m while in ARMED -> sync_out high in cycle m+1 for exactly 1 cycle, and fft_shift updates on the same edge.
- HOLDOFF occupies cycles m+2 .. m+1+HOLDOFF_CYCLES. The earliest next sync_out accepted is at cycle m+2+HOLDOFF_CYCLES.
- arm_e and sync_in in the same cycle while in IDLE: the arm takes effect and that sync is dropped.
- sync_in in the same cycle as arm_e while in ARMED: fires using the newly captured shift.
- Reset asserted mid-operation forces all reset values immediately; no sync_out may be emitted after reset assertion.
- Counters update 1 cycle after their cause. status_word is registered and lags the counters by 1 cycle.

## Test plan
- Reset, then idle with sync_in pulsing every 100 cycles -> sync_out stays 0, fft_shift=0xFFF, status_word=0.
- Write ctrl_word=0x0000_0AB1 (arm, shift=0xAB), then sync_in at cycle 50 -> exactly one sync_out at cycle 51, fft_shift=0x0AB, sync_cnt=1, then return to IDLE after 16 holdoff cycles.
- Arm, fire, re-arm 5 cycles into HOLDOFF with shift 0x123, sync_in at holdoff cycle 10 and again 30 cycles after fire:
  - the first sync is ignored;
  - the second emits sync_out with fft_shift=0x123.
- Hold fft_of high for 70000 cycles -> of_cnt=0xFFFF. Toggle clr_status in a cycle with fft_of=1 -> of_cnt=0.
- Fire 257 armed syncs -> sync_cnt=1 (wrap).
- Set ctrl_word[31] while ARMED -> dp_rst=1 next cycle, state IDLE, subsequent sync_in ignored. Assert OPB_Rst during FIRE -> sync_out drops immediately and all outputs take their reset values.
